mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, byte-address width.
REQ-002 SHALL have parameter DW, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clka, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_req, input, 1, instruction-fetch read request; held until i_done.
REQ-006 SHALL have port i_addr, input, AW, fetch byte address.
REQ-007 SHALL have port i_rdata, output, DW, fetched word.
REQ-008 SHALL have port i_done, output, 1, one-cycle fetch-complete pulse.
REQ-009 SHALL have port d_req, input, 1, data request; held until d_done.
REQ-010 SHALL have port d_we, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port d_be, input, 4, write byte enables.
REQ-012 SHALL have port d_addr, input, AW, data byte address.
REQ-013 SHALL have port d_wdata, input, DW, write data.
REQ-014 SHALL have port d_rdata, output, DW, read word.
REQ-015 SHALL have port d_done, output, 1, one-cycle data-complete pulse.
REQ-016 SHALL have port ram_en, output, 1, shared RAM enable.
REQ-017 SHALL have port ram_we, output, 4, shared RAM byte write enables.
REQ-018 SHALL have port ram_addr, output, AW, shared RAM byte address.
REQ-019 SHALL have port ram_wdata, output, DW, shared RAM write data.
REQ-020 SHALL have port ram_rdata, input, DW, shared RAM read data, valid one cycle after ram_en.
REQ-021 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE_I, RESP_I, ISSUE_D, RESP_D.
REQ-023 IDLE SHALL go to ISSUE_I if only i_req is high, to ISSUE_D if only d_req is high, and stay in IDLE if neither is high.
REQ-024 SHALL resolve a tie (both requests high in IDLE) round-robin: grant the requester not in last_grant; last_grant resets to I, so data wins the first tie.
REQ-025 SHALL, on the IDLE->ISSUE transition, latch the winner's addr, we, be and wdata into internal registers; later requester input changes SHALL have no effect.
REQ-026 ISSUE_x SHALL drive ram_en=1, ram_addr={latched addr[AW-1:2],2'b00}, and ram_wdata=latched wdata.
REQ-027 ISSUE_x SHALL drive ram_we=latched be when x is a data write, else 4'b0000.
REQ-028 ISSUE_x SHALL always go to RESP_x next, and SHALL update last_grant to x.
REQ-029 RESP_x SHALL pulse x_done for exactly one cycle, SHALL register ram_rdata into x_rdata for reads, and SHALL return to IDLE.
REQ-030 d_rdata SHALL be unchanged on writes.
REQ-031 Latency SHALL be: request first high at edge k in IDLE -> ISSUE at k+1 -> done high during cycle after k+1 -> IDLE at k+2; one transaction per 3 cycles maximum.
REQ-032 i_rdata and d_rdata SHALL hold their values until the next read of the same requester.
REQ-033 Outside ISSUE states, ram_en and ram_we SHALL be 0, and ram_addr and ram_wdata SHALL hold their last values.
REQ-034 The low two address bits SHALL be ignored; no alignment error is reported.
REQ-035 A requester that keeps req high in its done cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-036 i_done and d_done SHALL never be high in the same cycle.

Reset
REQ-037 rst=0 SHALL immediately force state=IDLE, last_grant=I, ram_en=0, ram_we=0, i_done=0, d_done=0, and busy=0.
REQ-038 rst=0 SHALL clear ram_addr, ram_wdata, i_rdata, d_rdata and the latched registers to 0.
REQ-039 Reset asserted mid-transaction SHALL abort it with no done pulse and no RAM write after assertion.
REQ-040 On reset release, the first rising edge SHALL evaluate requests from IDLE.

Verification
REQ-041 Single fetch: i_req=1, i_addr=0x10, RAM word4=0x2402000A -> ram_en one cycle with ram_addr=0x10; i_done one cycle later with i_rdata=0x2402000A.
REQ-042 Data write: d_we=1, d_be=4'hF, d_addr=0x54, d_wdata=0x7 -> ram_we=4'hF for one cycle; then d_done; a readback of 0x54 returns 0x7.
REQ-043 Tie out of reset: i_req and d_req high together -> data served first; fetch issued in the IDLE cycle after d_done; grants alternate D,I,D,I while both are held.
REQ-044 Unaligned address: d_addr=0x57 read -> ram_addr=0x54.
REQ-045 Reset mid-operation: rst=0 during ISSUE_D write -> ram_we drops immediately; no d_done; busy=0.
REQ-046 Input change: d_addr changed during ISSUE_D -> ram_addr keeps the latched value.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between an instruction
// fetch port and a data load/store port. One transaction at a time takes
// three cycles: IDLE -> ISSUE -> RESP. When both ports request in the same
// IDLE cycle, the port that was not served last wins.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE_I = 3'd1;
  localparam logic [2:0] RESP_I  = 3'd2;
  localparam logic [2:0] ISSUE_D = 3'd3;
  localparam logic [2:0] RESP_D  = 3'd4;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic          last_grant_r;
  logic          take_i_s;
  logic          take_d_s;

  // Transaction context captured when a request is granted.
  logic [AW-1:0] lat_addr_r;
  logic [DW-1:0] lat_wdata_r;
  logic          lat_we_r;

  logic          ram_en_r;
  logic [3:0]    ram_we_r;
  logic          i_done_r;
  logic          d_done_r;
  logic          busy_r;
  logic [DW-1:0] i_rdata_r;
  logic [DW-1:0] d_rdata_r;

  // The RAM is word addressed in effect; the byte offset is dropped.
  logic          addr_lsb_unused_s;
  assign addr_lsb_unused_s = ^lat_addr_r[1:0];

  // Next-state decode with round-robin tie break in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    take_i_s    = 1'b0;
    take_d_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant_r == LG_I) begin
            take_d_s    = 1'b1;
            state_nxt_s = ISSUE_D;
          end else begin
            take_i_s    = 1'b1;
            state_nxt_s = ISSUE_I;
          end
        end else if (d_req) begin
          take_d_s    = 1'b1;
          state_nxt_s = ISSUE_D;
        end else if (i_req) begin
          take_i_s    = 1'b1;
          state_nxt_s = ISSUE_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE_I: state_nxt_s = RESP_I;
      RESP_I:  state_nxt_s = IDLE;
      ISSUE_D: state_nxt_s = RESP_D;
      RESP_D:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and record of which port was served last.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= LG_I;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ISSUE_I) begin
        last_grant_r <= LG_I;
      end else if (state_r == ISSUE_D) begin
        last_grant_r <= LG_D;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Capture the winner's request so later input changes cannot disturb it.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      lat_addr_r  <= {AW{1'b0}};
      lat_wdata_r <= {DW{1'b0}};
      lat_we_r    <= 1'b0;
    end else if (take_d_s) begin
      lat_addr_r  <= d_addr;
      lat_wdata_r <= d_wdata;
      lat_we_r    <= d_we;
    end else if (take_i_s) begin
      lat_addr_r  <= i_addr;
      lat_wdata_r <= {DW{1'b0}};
      lat_we_r    <= 1'b0;
    end else begin
      lat_addr_r  <= lat_addr_r;
      lat_wdata_r <= lat_wdata_r;
      lat_we_r    <= lat_we_r;
    end
  end

  // Registered RAM strobes, done pulses and busy, all decoded from next state.
  // ram_we_r also serves as the latched byte enables of a granted write.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      ram_en_r <= 1'b0;
      ram_we_r <= 4'b0000;
      i_done_r <= 1'b0;
      d_done_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      ram_en_r <= take_i_s | take_d_s;
      ram_we_r <= (take_d_s && d_we) ? d_be : 4'b0000;
      i_done_r <= (state_nxt_s == RESP_I);
      d_done_r <= (state_nxt_s == RESP_D);
      busy_r   <= (state_nxt_s != IDLE);
    end
  end

  // Capture read data in the response cycle; writes leave d_rdata alone.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      i_rdata_r <= {DW{1'b0}};
      d_rdata_r <= {DW{1'b0}};
    end else begin
      if (state_r == RESP_I) begin
        i_rdata_r <= ram_rdata;
      end else begin
        i_rdata_r <= i_rdata_r;
      end
      if ((state_r == RESP_D) && !lat_we_r) begin
        d_rdata_r <= ram_rdata;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = {lat_addr_r[AW-1:2], 2'b00};
  assign ram_wdata = lat_wdata_r;
  assign i_done    = i_done_r;
  assign d_done    = d_done_r;
  assign busy      = busy_r;
  assign i_rdata   = i_rdata_r;
  assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural synchronous RAM, a table of single
// transactions with hand-computed results, and directed multi-cycle sequences
// for tie-breaking, reset abort and input changes during a transaction.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clka = 1'b0;
  logic          rst  = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = 4'h0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clka(clka), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clka = ~clka;

  // Synchronous RAM model: read-before-write, data valid one cycle after ram_en.
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b0;
  always @(posedge clka) begin
    if (!mem_init) begin
      for (int k = 0; k < 64; k++) mem[k] = 32'hA500_0000 | k;
      mem[4] = 32'h2402_000A;
      mem_init = 1'b1;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:2]][8*b +: 8] = ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_rdata;  // rdata of the serving port after the transaction
  } vec_t;

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n_ev;
    int   ev_cyc [4];
    logic ev_d   [4];
    logic exp_ev [4];

    exp_ev[0] = 1'b1; exp_ev[1] = 1'b0; exp_ev[2] = 1'b1; exp_ev[3] = 1'b0;

    //           is_d  we    be     addr           wdata          exp_addr       exp_we   exp_rdata
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h0000_0010, 4'h0, 32'h2402_000A};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0054, 32'h0000_0007, 32'h0000_0054, 4'hF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0054, 32'h0,         32'h0000_0054, 4'h0, 32'h0000_0007};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h0000_0057, 32'h0,         32'h0000_0054, 4'h0, 32'h0000_0007};
    vecs[4] = '{1'b1, 1'b1, 4'h5, 32'h0000_0020, 32'h1122_3344, 32'h0000_0020, 4'h5, 32'h0000_0007};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h0000_0020, 4'h0, 32'hA522_0044};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_0023, 32'h0,         32'h0000_0020, 4'h0, 32'hA522_0044};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h0000_0000, 4'h0, 32'hA500_0000};

    // Reset state
    repeat (2) @(negedge clka);
    chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
    chk("rst_ram_we", {28'b0, ram_we}, 32'h0);
    chk("rst_done", {30'b0, i_done, d_done}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clka);

    // Table of single transactions
    for (int n = 0; n < 8; n++) begin
      v = vecs[n];
      i_req = ~v.is_d; i_addr = v.addr;
      d_req = v.is_d; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      @(negedge clka);  // ISSUE
      chk($sformatf("v%0d_issue_en", n), {31'b0, ram_en}, 32'h1);
      chk($sformatf("v%0d_issue_addr", n), ram_addr, v.exp_addr);
      chk($sformatf("v%0d_issue_we", n), {28'b0, ram_we}, {28'b0, v.exp_we});
      if (v.is_d) chk($sformatf("v%0d_issue_wdata", n), ram_wdata, v.wdata);
      chk($sformatf("v%0d_issue_done", n), {30'b0, i_done, d_done}, 32'h0);
      chk($sformatf("v%0d_issue_busy", n), {31'b0, busy}, 32'h1);
      @(negedge clka);  // RESP
      chk($sformatf("v%0d_resp_done", n), {30'b0, i_done, d_done}, {30'b0, ~v.is_d, v.is_d});
      chk($sformatf("v%0d_resp_strobes", n), {27'b0, ram_en, ram_we}, 32'h0);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clka);  // IDLE
      chk($sformatf("v%0d_rdata", n), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
      chk($sformatf("v%0d_idle_done", n), {30'b0, i_done, d_done}, 32'h0);
      chk($sformatf("v%0d_idle_busy", n), {31'b0, busy}, 32'h0);
      chk($sformatf("v%0d_idle_addr_hold", n), ram_addr, v.exp_addr);
    end

    // Tie out of reset: data first, then alternate while both are held
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h54;
    @(negedge clka);
    rst = 1'b1;
    n_ev = 0;
    for (int cyc = 0; cyc < 20 && n_ev < 4; cyc++) begin
      @(negedge clka);
      if (i_done && d_done) chk("tie_both_done", 32'h1, 32'h0);
      if (i_done || d_done) begin
        ev_cyc[n_ev] = cyc;
        ev_d[n_ev]   = d_done;
        n_ev++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("tie_event_count", n_ev, 4);
    for (int e = 0; e < 4; e++) begin
      if (e < n_ev) begin
        chk($sformatf("tie_grant%0d", e), {31'b0, ev_d[e]}, {31'b0, exp_ev[e]});
        chk($sformatf("tie_cycle%0d", e), ev_cyc[e], 1 + 3 * e);
      end
    end
    @(negedge clka);
    chk("tie_d_rdata", d_rdata, 32'h0000_0007);
    chk("tie_i_rdata", i_rdata, 32'h2402_000A);
    chk("tie_busy_end", {31'b0, busy}, 32'h0);

    // Reset asserted during an ISSUE_D write
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h30; d_wdata = 32'hDEAD_BEEF;
    @(negedge clka);
    chk("abort_we_before", {28'b0, ram_we}, 32'hF);
    #2 rst = 1'b0;
    #1;
    chk("abort_we", {28'b0, ram_we}, 32'h0);
    chk("abort_en", {31'b0, ram_en}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_ram_addr", ram_addr, 32'h0);
    chk("abort_ram_wdata", ram_wdata, 32'h0);
    chk("abort_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clka);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clka);
      chk($sformatf("abort_no_done%0d", c), {30'b0, i_done, d_done}, 32'h0);
    end
    chk("abort_mem_untouched", mem[12], 32'hA500_000C);

    // Requester inputs change while the read is in flight
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h54; d_wdata = 32'h0;
    @(negedge clka);  // ISSUE_D
    d_addr = 32'h08; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'hFFFF_FFFF;
    #1;
    chk("chg_issue_addr", ram_addr, 32'h54);
    chk("chg_issue_we", {28'b0, ram_we}, 32'h0);
    @(negedge clka);  // RESP_D
    chk("chg_done", {30'b0, i_done, d_done}, 32'h1);
    chk("chg_resp_addr", ram_addr, 32'h54);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clka);
    chk("chg_d_rdata", d_rdata, 32'h0000_0007);
    chk("chg_idle_addr", ram_addr, 32'h54);
    chk("chg_mem2_untouched", mem[2], 32'hA500_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
